// File: rtl/xor_initiator.sv
// xor_initiator: LFSR-driven XOR operand initiator with in-order result scoreboard (optional XOR_INIT_BACKPRESSURE_EN gates Y_ready)
module xor_initiator #(
  parameter logic [7:0] SEED     = 8'hA5,
  parameter int         SB_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] num_txn,
  output logic       A_data,
  output logic       A_enable,
  input  logic       A_ready,
  output logic       B_data,
  output logic       B_enable,
  input  logic       B_ready,
  input  logic       Y_data,
  input  logic       Y_enable,
  output logic       Y_ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] pass_cnt,
  output logic [7:0] err_cnt
);
  localparam int AW = $clog2(SB_DEPTH);
  localparam logic [7:0] L_SEED = (SEED == 8'h00) ? 8'h01 : SEED;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        r_state, w_next;
  logic [7:0]    r_lfsr, r_num, r_sent, r_pass, r_err;
  logic          r_a_en, r_b_en, r_a_d, r_b_d;
  logic          r_sb [SB_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_full, w_empty, w_pop, w_launch, w_start, w_y_ok;

  assign w_full   = r_cnt[AW];
  assign w_empty  = (r_cnt == '0);
  assign w_start  = (r_state == IDLE) && start && (num_txn != 8'd0);
  assign busy     = (r_state == RUN) || (r_state == DRAIN);
  assign done     = (r_state == DONE);
  assign Y_ready  = busy && !w_empty && w_y_ok;
  assign w_pop    = Y_enable && Y_ready;
  assign w_launch = (r_state == RUN) && !r_a_en && !r_b_en && (!w_full || w_pop) && (r_sent < r_num);
  assign A_enable = r_a_en;
  assign B_enable = r_b_en;
  assign A_data   = r_a_d;
  assign B_data   = r_b_d;
  assign pass_cnt = r_pass;
  assign err_cnt  = r_err;

`ifdef XOR_INIT_BACKPRESSURE_EN
  logic [3:0] r_bp;
  // free-running x^4+x^3+1 sequence; Y is held off whenever its low two bits are zero
  always_ff @(posedge clk) begin
    if (!reset_n) r_bp <= 4'h9;
    else          r_bp <= {r_bp[2:0], r_bp[3] ^ r_bp[2]};
  end
  assign w_y_ok = (r_bp[1:0] != 2'b00);
`else
  assign w_y_ok = 1'b1;
`endif

  // run sequencing: zero-length runs go straight to DONE, DRAIN waits for every result
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = (num_txn == 8'd0) ? DONE : RUN;
      RUN:     if (r_sent == r_num) w_next = DRAIN;
      DRAIN:   if (w_empty) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // operand channels: a launch raises both enables, each drops after its own acceptance
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_a_en <= 1'b0;
      r_b_en <= 1'b0;
      r_a_d  <= 1'b0;
      r_b_d  <= 1'b0;
      r_lfsr <= L_SEED;
      r_sent <= 8'd0;
      r_num  <= 8'd0;
    end else begin
      if (w_launch) begin
        r_a_en <= 1'b1;
        r_b_en <= 1'b1;
        r_a_d  <= r_lfsr[0];
        r_b_d  <= r_lfsr[1];
        r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        r_sent <= r_sent + 8'd1;
      end else begin
        if (r_a_en && A_ready) r_a_en <= 1'b0;
        if (r_b_en && B_ready) r_b_en <= 1'b0;
      end
      if (w_start) begin
        r_num  <= num_txn;
        r_sent <= 8'd0;
      end
    end
  end

  // expected-result storage; contents need no reset because occupancy gates every read
  always_ff @(posedge clk) begin
    if (w_launch) r_sb[r_wp] <= r_lfsr[0] ^ r_lfsr[1];
  end

  // scoreboard pointers and occupancy; simultaneous push and pop leave occupancy unchanged
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_launch) r_wp <= r_wp + 1'b1;
      if (w_pop)    r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + {{AW{1'b0}}, w_launch} - {{AW{1'b0}}, w_pop};
    end
  end

  // saturating match/mismatch counters, cleared when a run begins
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pass <= 8'd0;
      r_err  <= 8'd0;
    end else if (w_start) begin
      r_pass <= 8'd0;
      r_err  <= 8'd0;
    end else if (w_pop) begin
      if (Y_data == r_sb[r_rp]) r_pass <= (r_pass == 8'hFF) ? r_pass : r_pass + 8'd1;
      else                      r_err  <= (r_err  == 8'hFF) ? r_err  : r_err  + 8'd1;
    end
  end
endmodule

// File: tb/tb_xor_initiator.sv
// tb_xor_initiator: randomized responder with a queue-based model of operands, scoreboard and counters
module tb_xor_initiator;
  localparam int DEPTH = 4;

  logic       clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [7:0] num_txn = 8'd0;
  logic       A_data, A_enable, A_ready = 1'b0;
  logic       B_data, B_enable, B_ready = 1'b0;
  logic       Y_data = 1'b0, Y_enable = 1'b0, Y_ready;
  logic       busy, done;
  logic [7:0] pass_cnt, err_cnt;

  int checks = 0, errors = 0;

  xor_initiator #(.SEED(8'hA5), .SB_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_txn(num_txn),
    .A_data(A_data), .A_enable(A_enable), .A_ready(A_ready),
    .B_data(B_data), .B_enable(B_enable), .B_ready(B_ready),
    .Y_data(Y_data), .Y_enable(Y_enable), .Y_ready(Y_ready),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0] m_lfsr = 8'hA5;
  bit         mq[$];
  bit         ra[$], rb[$];
  int         m_pass = 0, m_err = 0, launches = 0, run_num = 0, peak = 0, lag = 0;
  int         start_count = 0, done_count = 0, y_idx = 0;
  int         rdy_mode = 0, corrupt_idx = -1, a_block = 0;
  bit         run_active = 0, withhold = 0, released = 0, y_valid = 0, just_reset = 0;
  bit         prev_a_en = 0, prev_b_en = 0, prev_a_d = 0, prev_b_d = 0, prev_done = 0, prev_rst = 1;
  bit         a_acc = 0, b_acc = 0;
  bit         pa[3], pb[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  initial forever begin
    @(negedge clk);
    if (just_reset) begin
      chk("rst_a_en", A_enable, 0); chk("rst_b_en", B_enable, 0);
      chk("rst_a_data", A_data, 0); chk("rst_b_data", B_data, 0);
      chk("rst_y_ready", Y_ready, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
      just_reset = 0;
    end
    if (!prev_rst) begin
      if (prev_a_en && !a_acc) begin chk("a_hold_en", A_enable, 1); chk("a_hold_data", A_data, prev_a_d); end
      if (prev_b_en && !b_acc) begin chk("b_hold_en", B_enable, 1); chk("b_hold_data", B_data, prev_b_d); end
      if (a_acc) chk("a_drop", A_enable, 0);
      if (b_acc) chk("b_drop", B_enable, 0);
    end
    if (A_enable && !prev_a_en) begin
      chk("launch_b_en", B_enable, 1);
      chk("launch_b_idle", prev_b_en, 0);
      chk("launch_a_data", A_data, m_lfsr[0]);
      chk("launch_b_data", B_data, m_lfsr[1]);
      if (launches < 3) begin pa[launches] = A_data; pb[launches] = B_data; end
      mq.push_back(m_lfsr[0] ^ m_lfsr[1]);
      m_lfsr = lfsr_next(m_lfsr);
      launches++;
      chk("launch_in_run", run_active && launches <= run_num, 1);
      chk("sb_bound", mq.size() <= DEPTH, 1);
      if (mq.size() > peak) peak = mq.size();
    end else if (B_enable && !prev_b_en) chk("b_rise_alone", 1, 0);
`ifdef XOR_INIT_BACKPRESSURE_EN
    chk("y_ready", Y_ready && !(busy && mq.size() > 0), 0);
`else
    chk("y_ready", Y_ready, busy && mq.size() > 0);
`endif
    chk("pass_cnt", pass_cnt, m_pass);
    chk("err_cnt", err_cnt, m_err);
    if (run_active && run_num == 0) chk("zero_run_done", done, 1);
    if (run_active && run_num > 0 && !done) chk("busy_in_run", busy, 1);
    if (!run_active) chk("idle_busy", busy, 0);
    if (run_active && run_num > 0 && launches == run_num && mq.size() == 0 && !done) begin
      lag++;
      chk("done_latency", lag <= 1, 1);
    end
    if (prev_done) chk("done_one_cycle", done, 0);
    if (done) begin
      chk("done_in_run", run_active, 1); chk("done_busy", busy, 0);
      chk("done_sb_empty", mq.size(), 0); chk("done_all_sent", launches, run_num);
      run_active = 0;
      done_count++;
    end
    if (withhold && mq.size() >= DEPTH) released = 1;
    A_ready = (a_block > 0) ? 1'b0 : (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(1));
    B_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(1));
    if (a_block > 0 && A_enable) a_block--;
    if (!y_valid && ra.size() > 0 && rb.size() > 0 && (!withhold || released) &&
        (rdy_mode == 0 || $urandom_range(3) != 0)) begin
      y_valid = 1;
      Y_data = ra.pop_front() ^ rb.pop_front() ^ (y_idx == corrupt_idx);
      y_idx++;
    end
    if (y_valid) Y_enable = 1'b1;
    else if (!run_active) begin Y_enable = 1'($urandom_range(1)); Y_data = 1'($urandom_range(1)); end
    else Y_enable = 1'b0;
    a_acc = reset_n && A_enable && A_ready;
    b_acc = reset_n && B_enable && B_ready;
    if (a_acc) ra.push_back(A_data);
    if (b_acc) rb.push_back(B_data);
    if (reset_n && y_valid && Y_ready && mq.size() > 0) begin
      if (Y_data == mq[0]) m_pass = (m_pass == 255) ? 255 : m_pass + 1;
      else                 m_err  = (m_err  == 255) ? 255 : m_err + 1;
      void'(mq.pop_front());
      y_valid = 0;
    end
    if (reset_n && start) begin
      run_active = 1; run_num = num_txn; launches = 0; peak = 0; y_idx = 0; lag = 0;
      start_count++;
      if (num_txn != 8'd0) begin m_pass = 0; m_err = 0; end
    end
    if (!reset_n) begin
      mq.delete(); ra.delete(); rb.delete();
      y_valid = 0; Y_enable = 1'b0; m_pass = 0; m_err = 0; launches = 0;
      run_active = 0; m_lfsr = 8'hA5; just_reset = 1; start_count = done_count;
    end
    prev_rst = !reset_n;
    prev_a_en = A_enable; prev_b_en = B_enable;
    prev_a_d = A_data; prev_b_d = B_data; prev_done = done;
  end

  task automatic kick(input int n, input int mode, input int cidx, input bit wh, input int blk);
    rdy_mode = mode; corrupt_idx = cidx; withhold = wh; released = 0; a_block = blk;
    num_txn = 8'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; num_txn = 8'($urandom);
  endtask

  task automatic finish_run(input string name, input int ep, input int ee);
    int i = 0;
    while (done_count < start_count && i < 4000) begin @(posedge clk); #1; i++; end
    chk({name, "_done"}, done_count, start_count);
    chk({name, "_pass"}, pass_cnt, ep);
    chk({name, "_err"}, err_cnt, ee);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("init_busy", busy, 0);
    chk("init_pass", pass_cnt, 0);

    kick(0, 0, -1, 0, 0);
    finish_run("zero", 0, 0);

    kick(8, 0, -1, 0, 0);
    finish_run("ideal8", 8, 0);
    chk("pair0_a", pa[0], 1); chk("pair0_b", pb[0], 0);
    chk("pair1_a", pa[1], 0); chk("pair1_b", pb[1], 1);
    chk("pair2_a", pa[2], 1); chk("pair2_b", pb[2], 0);

    kick(5, 0, 2, 0, 0);
    finish_run("corrupt3", 4, 1);

    kick(3, 0, -1, 0, 10);
    for (int i = 0; i < 20 && !A_enable; i++) begin @(posedge clk); #1; end
    chk("ablock_launched", A_enable, 1);
    repeat (8) @(posedge clk);
    #1;
    chk("ablock_a_en", A_enable, 1);
    chk("ablock_b_en", B_enable, 0);
    chk("ablock_launches", launches, 1);
    finish_run("ablock", 3, 0);

    kick(6, 0, -1, 1, 0);
    finish_run("withhold", 6, 0);
    chk("withhold_peak", peak, DEPTH);

    for (int k = 0; k < 4; k++) begin
      int n, c;
      n = int'($urandom_range(20, 1));
      c = ($urandom_range(1) == 1) ? int'($urandom_range(n - 1)) : -1;
      kick(n, 1, c, 0, 0);
      finish_run("rand", n - ((c >= 0) ? 1 : 0), (c >= 0) ? 1 : 0);
    end

    kick(10, 1, -1, 0, 0);
    for (int i = 0; i < 200 && launches < 3; i++) begin @(posedge clk); #1; end
    chk("midrst_reached3", launches, 3);
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_y_ready", Y_ready, 0);
    chk("midrst_a_en", A_enable, 0);
    chk("midrst_pass", pass_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    kick(2, 1, -1, 0, 0);
    finish_run("after_rst", 2, 0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/xor_initiator.md
XOR_INITIATOR -- requirements
Module: xor_initiator

Interface
REQ-001 The block SHALL have parameter SEED, default 8'hA5, operand LFSR reset value; a value of zero SHALL be replaced by 8'h01.
REQ-002 The block SHALL have parameter SB_DEPTH, default 4, scoreboard entries (power of two, 2..16).
REQ-003 The block SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, begin a run (sampled in IDLE only).
REQ-006 The block SHALL have port num_txn, input, 8, operand pairs to issue (sampled with start).
REQ-007 The block SHALL have ports A_data/A_enable, output, 1 each, and A_ready, input, 1: operand A channel.
REQ-008 The block SHALL have ports B_data/B_enable, output, 1 each, and B_ready, input, 1: operand B channel.
REQ-009 The block SHALL have ports Y_data/Y_enable, input, 1 each, and Y_ready, output, 1: result channel.
REQ-010 The block SHALL have port busy, output, 1, high in RUN or DRAIN.
REQ-011 The block SHALL have port done, output, 1, one-cycle pulse at run end.
REQ-012 The block SHALL have ports pass_cnt and err_cnt, output, 8 each, matched/mismatched results.

Function
REQ-013 A transfer SHALL occur on a channel at a rising clk edge where enable and ready are both high; data and enable SHALL hold stable until accepted.
REQ-014 FSM states SHALL be IDLE, RUN, DRAIN, DONE: IDLE->RUN on start with num_txn>0; IDLE->DONE on start with num_txn==0; RUN->DRAIN when sent count equals num_txn; DRAIN->DONE when scoreboard empty; DONE->IDLE unconditionally after one cycle.
REQ-015 On entry to RUN, pass_cnt, err_cnt and sent count SHALL clear; counters SHALL hold their values in IDLE and DONE.
REQ-016 In RUN, a pair launch SHALL occur when neither channel holds a pending transfer, the scoreboard is not full and sent<num_txn: A_data=lfsr[0], B_data=lfsr[1], both enables rise in the next cycle, expected value A^B is pushed, sent increments, and the LFSR advances.
REQ-017 The operand LFSR SHALL be 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, and SHALL advance only on launch.
REQ-018 Each channel enable SHALL drop independently in the cycle after its own acceptance; the next launch SHALL wait until both have dropped.
REQ-019 Y_ready SHALL be high only in RUN or DRAIN with a non-empty scoreboard; Y_enable with an empty scoreboard SHALL be ignored and not counted.
REQ-020 On Y acceptance the oldest expected entry SHALL pop; pass_cnt increments if Y_data matches it, else err_cnt increments; both counters SHALL saturate at 8'hFF.
REQ-021 A push and a pop in the same cycle SHALL both take effect with occupancy unchanged; a launch SHALL be allowed when full only if a pop occurs that cycle.
REQ-022 start SHALL be ignored outside IDLE; num_txn changes after the start cycle SHALL have no effect.
REQ-023 done SHALL be high exactly in the DONE cycle.

Reset
REQ-024 While reset_n is low at a clk edge, state SHALL become IDLE; A_enable, B_enable, A_data, B_data, Y_ready, busy, done SHALL be 0; pass_cnt, err_cnt and sent SHALL be 0; the scoreboard SHALL be emptied; the LFSR SHALL load SEED.
REQ-025 Reset asserted mid-run SHALL abandon pending transfers without completing them or counting them.

Configuration
REQ-026 With XOR_INIT_BACKPRESSURE_EN defined, Y_ready SHALL additionally be forced low whenever a free-running 4-bit LFSR (seed 4'h9, taps x^4+x^3+1, advancing every cycle out of reset) has bits [1:0]==2'b00.
REQ-027 Without XOR_INIT_BACKPRESSURE_EN, Y_ready SHALL follow REQ-019 only, and the 4-bit LFSR SHALL be absent.

Verification
REQ-028 Against an ideal XOR responder with ready tied high, start with num_txn=8 -> eight pairs issued, pass_cnt=8, err_cnt=0, and a single-cycle done pulse.
REQ-029 With a responder returning inverted Y on the 3rd transaction, num_txn=5 -> pass_cnt=4 and err_cnt=1.
REQ-030 With A_ready held low for 10 cycles and B_ready high -> B_enable drops after one cycle, A_enable stays high with stable A_data, and no new launch occurs until A is accepted.
REQ-031 With a responder that withholds Y until four pairs are outstanding and SB_DEPTH=4 -> no fifth launch occurs while the scoreboard is full, and the run completes with num_txn=6 and pass_cnt=6.
REQ-032 start with num_txn=0 -> done pulses on the next cycle, busy never rises, and both counters read 0.
REQ-033 With reset_n asserted during RUN at sent=3 -> the next cycle shows all outputs at their reset values and an empty scoreboard; a new start with num_txn=2 then yields pass_cnt=2.
